// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, ALU and response signals of the two-requester ALU arbiter.
//
// Handshake rules:
//   Request: a requester raises rN_valid with rN_op/rN_a/rN_b and holds all of
//   them until it sees rN_ready high. rN_ready is combinational and is high
//   only in the single cycle where the payload is taken.
//   Response: rsp_valid high means rsp_id/rsp_data/rsp_err are valid. They stay
//   stable until a rising edge where rsp_valid && rsp_ready completes the
//   transfer. rsp_ready is ignored while rsp_valid is low.
//
// state is a read-only view of the arbiter FSM (0 IDLE, 1 ISSUE, 2 RESP).
interface alu_arbiter_if;
  logic       r0_valid;
  logic       r0_ready;
  logic [2:0] r0_op;
  logic [7:0] r0_a;
  logic [7:0] r0_b;
  logic       r1_valid;
  logic       r1_ready;
  logic [2:0] r1_op;
  logic [7:0] r1_a;
  logic [7:0] r1_b;
  logic [2:0] alu_inst;
  logic [7:0] alu_op1;
  logic [7:0] alu_op2;
  logic [7:0] alu_sol;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [1:0] state;

  // Environment side: requesters, ALU and response consumer.
  modport master (
    output r0_valid, r0_op, r0_a, r0_b,
    output r1_valid, r1_op, r1_a, r1_b,
    output alu_sol, rsp_ready,
    input  r0_ready, r1_ready, alu_inst, alu_op1, alu_op2,
    input  rsp_valid, rsp_id, rsp_data, rsp_err, state
  );

  // Arbiter side.
  modport slave (
    input  r0_valid, r0_op, r0_a, r0_b,
    input  r1_valid, r1_op, r1_a, r1_b,
    input  alu_sol, rsp_ready,
    output r0_ready, r1_ready, alu_inst, alu_op1, alu_op2,
    output rsp_valid, rsp_id, rsp_data, rsp_err, state
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 8-bit add/sub ALU between two
// requesters. One operation is in flight at a time: IDLE grants, ISSUE drives
// the ALU and captures its result, RESP holds the result until consumed.
//
// Optional feature: define ALU_ARBITER_RR_EN for round-robin arbitration on
// contention; otherwise requester 0 has fixed priority.
module alu_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;

  state_t     state;
  logic       err_q;
  logic       any_req;
  logic       grant_id;
  logic [2:0] win_op;
  logic [7:0] win_a;
  logic [7:0] win_b;
  logic       win_legal;

`ifdef ALU_ARBITER_RR_EN
  logic       last_grant;
`endif

  assign bus.state = state;

  // Pick the winning requester; grant_id is its index.
  always_comb begin
    any_req = bus.r0_valid | bus.r1_valid;
`ifdef ALU_ARBITER_RR_EN
    if (bus.r0_valid && bus.r1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = ~bus.r0_valid;
    end
`else
    grant_id = ~bus.r0_valid;
`endif
  end

  // Winner payload mux and op legality.
  always_comb begin
    win_op    = grant_id ? bus.r1_op : bus.r0_op;
    win_a     = grant_id ? bus.r1_a  : bus.r0_a;
    win_b     = grant_id ? bus.r1_b  : bus.r0_b;
    win_legal = (win_op == OP_ADD) || (win_op == OP_SUB);
  end

  // Ready only in IDLE, and held low while reset is asserted.
  always_comb begin
    bus.r0_ready = 1'b0;
    bus.r1_ready = 1'b0;
    if (rst_n && (state == IDLE) && any_req) begin
      bus.r0_ready = ~grant_id;
      bus.r1_ready = grant_id;
    end
  end

  // Control FSM; the ALU drive registers double as the latched operation and
  // are zero everywhere except during ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      err_q        <= 1'b0;
      bus.alu_inst <= 3'b000;
      bus.alu_op1  <= 8'h00;
      bus.alu_op2  <= 8'h00;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id   <= 1'b0;
      bus.rsp_data <= 8'h00;
      bus.rsp_err  <= 1'b0;
`ifdef ALU_ARBITER_RR_EN
      last_grant   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            // Illegal ops still go through ISSUE but never reach the ALU.
            bus.alu_inst <= win_legal ? win_op : 3'b000;
            bus.alu_op1  <= win_a;
            bus.alu_op2  <= win_b;
            err_q        <= ~win_legal;
            bus.rsp_id   <= grant_id;
`ifdef ALU_ARBITER_RR_EN
            last_grant   <= grant_id;
`endif
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          // Do not capture the ALU output for illegal ops: it may be X/Z.
          bus.rsp_data  <= err_q ? 8'h00 : bus.alu_sol;
          bus.rsp_err   <= err_q;
          bus.rsp_valid <= 1'b1;
          bus.alu_inst  <= 3'b000;
          bus.alu_op1   <= 8'h00;
          bus.alu_op2   <= 8'h00;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a
// behavioural model (operation result, winner choice, response timing).
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_arbiter_if bus();

  alu_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Combinational ALU; garbage for anything that is not add/sub.
  always_comb begin
    case (bus.alu_inst)
      3'b001:  bus.alu_sol = bus.alu_op1 + bus.alu_op2;
      3'b010:  bus.alu_sol = bus.alu_op1 - bus.alu_op2;
      default: bus.alu_sol = 8'h5A;
    endcase
  end

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {err, id, data}
  logic [9:0] exp_q[$];
  logic       m_last = 1'b1;
  logic [9:0] obs;
  logic       won;

  // Expected response from the arithmetic rules.
  function automatic logic [9:0] model_resp(input logic id, input logic [2:0] op,
                                            input logic [7:0] a, input logic [7:0] b);
    int r;
    if (op == 3'd1) begin
      r = (int'(a) + int'(b)) % 256;
    end else if (op == 3'd2) begin
      r = (int'(a) - int'(b) + 256) % 256;
    end else begin
      return {1'b1, id, 8'h00};
    end
    return {1'b0, id, r[7:0]};
  endfunction

  // Expected winner given the current valids.
  function automatic logic model_pick(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef ALU_ARBITER_RR_EN
      return ~m_last;
`else
      return 1'b0;
`endif
    end
    return ~v0;
  endfunction

  // Driver: one full transaction, called and returning at a negedge in IDLE.
  task automatic txn(input logic v0, input logic v1,
                     input logic [2:0] op0, input logic [2:0] op1,
                     input logic [7:0] a0, input logic [7:0] b0,
                     input logic [7:0] a1, input logic [7:0] b1,
                     input int bp, input logic early_rdy,
                     output logic w, output logic [9:0] got);
    logic [9:0] e;
    logic [2:0] wop;
    logic [7:0] wa;
    logic [7:0] wb;
    logic [2:0] exp_inst;
    bus.r0_valid = v0; bus.r0_op = op0; bus.r0_a = a0; bus.r0_b = b0;
    bus.r1_valid = v1; bus.r1_op = op1; bus.r1_a = a1; bus.r1_b = b1;
    #1;
    w = model_pick(v0, v1);
    checks++;
    if ({bus.r1_ready, bus.r0_ready} !== (w ? 2'b10 : 2'b01))
      begin errors++; $display("FAIL grant: ready r1r0=%b expected %b", {bus.r1_ready, bus.r0_ready}, (w ? 2'b10 : 2'b01)); end
    m_last = w;
    wop = w ? op1 : op0;
    wa  = w ? a1 : a0;
    wb  = w ? b1 : b0;
    exp_q.push_back(model_resp(w, wop, wa, wb));
    exp_inst = (wop == 3'd1 || wop == 3'd2) ? wop : 3'b000;
    @(negedge clk);  // ISSUE
    checks++;
    if ({bus.alu_inst, bus.alu_op1, bus.alu_op2, bus.r0_ready, bus.r1_ready, bus.rsp_valid} !==
        {exp_inst, wa, wb, 3'b000})
      begin errors++; $display("FAIL issue: inst=%h op1=%h op2=%h rdy=%b%b vld=%b expected inst=%h op1=%h op2=%h rdy=00 vld=0",
        bus.alu_inst, bus.alu_op1, bus.alu_op2, bus.r0_ready, bus.r1_ready, bus.rsp_valid, exp_inst, wa, wb); end
    // Winner drops valid and scrambles its payload; loser keeps requesting.
    if (w) begin bus.r1_valid = 1'b0; bus.r1_a = 8'($urandom); end
    else   begin bus.r0_valid = 1'b0; bus.r0_a = 8'($urandom); end
    bus.rsp_ready = early_rdy;
    @(negedge clk);  // RESP
    bus.rsp_ready = 1'b0;
    e = exp_q.pop_front();
    for (int i = 0; i <= bp; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_data, bus.r0_ready, bus.r1_ready, bus.alu_inst} !==
          {1'b1, e, 2'b00, 3'b000})
        begin errors++; $display("FAIL resp[%0d]: vld=%b err=%b id=%b data=%h rdy=%b%b inst=%h expected vld=1 err=%b id=%b data=%h rdy=00 inst=0",
          i, bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_data, bus.r0_ready, bus.r1_ready, bus.alu_inst, e[9], e[8], e[7:0]); end
      if (i == bp) bus.rsp_ready = 1'b1;
      @(negedge clk);
    end
    got = {bus.rsp_err, bus.rsp_id, bus.rsp_data};
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0)
      begin errors++; $display("FAIL release: rsp_valid=%b expected 0", bus.rsp_valid); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.r0_valid = 1'b1; bus.r1_valid = 1'b1;
    #1;
    checks++;
    if ({bus.r0_ready, bus.r1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err,
         bus.alu_inst, bus.alu_op1, bus.alu_op2} !== 32'h0)
      begin errors++; $display("FAIL reset_values: rdy=%b%b vld=%b id=%b data=%h err=%b inst=%h op1=%h op2=%h expected all zero",
        bus.r0_ready, bus.r1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.alu_inst, bus.alu_op1, bus.alu_op2); end
    @(negedge clk);
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    rst_n = 1'b1;
    m_last = 1'b1;
  endtask

  task automatic test_idle();
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({bus.r0_ready, bus.r1_ready, bus.rsp_valid, bus.alu_inst, bus.alu_op1, bus.alu_op2} !== 22'h0)
        begin errors++; $display("FAIL idle[%0d]: rdy=%b%b vld=%b inst=%h op1=%h op2=%h expected all zero",
          i, bus.r0_ready, bus.r1_ready, bus.rsp_valid, bus.alu_inst, bus.alu_op1, bus.alu_op2); end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_single_add();
    txn(1'b1, 1'b0, 3'b001, 3'b000, 8'h12, 8'h34, 8'h00, 8'h00, 0, 1'b0, won, obs);
    checks++;
    if (obs !== {1'b0, 1'b0, 8'h46})
      begin errors++; $display("FAIL single_add: got err/id/data=%h expected %h", obs, {1'b0, 1'b0, 8'h46}); end
  endtask

  task automatic test_wrap();
    txn(1'b0, 1'b1, 3'b000, 3'b010, 8'h00, 8'h00, 8'h00, 8'h01, 0, 1'b0, won, obs);
    checks++;
    if (obs !== {1'b0, 1'b1, 8'hFF})
      begin errors++; $display("FAIL wrap_sub: got %h expected %h", obs, {1'b0, 1'b1, 8'hFF}); end
    txn(1'b1, 1'b0, 3'b001, 3'b000, 8'hFF, 8'h01, 8'h00, 8'h00, 0, 1'b0, won, obs);
    checks++;
    if (obs !== {1'b0, 1'b0, 8'h00})
      begin errors++; $display("FAIL wrap_add: got %h expected %h", obs, {1'b0, 1'b0, 8'h00}); end
  endtask

  task automatic test_illegal_backpressure();
    txn(1'b1, 1'b0, 3'b111, 3'b000, 8'hC3, 8'h7E, 8'h00, 8'h00, 5, 1'b1, won, obs);
    checks++;
    if (obs !== {1'b1, 1'b0, 8'h00})
      begin errors++; $display("FAIL illegal: got %h expected %h", obs, {1'b1, 1'b0, 8'h00}); end
  endtask

  task automatic test_mid_reset();
    bus.r1_valid = 1'b1; bus.r1_op = 3'b001; bus.r1_a = 8'h21; bus.r1_b = 8'h43;
    bus.r0_valid = 1'b0;
    @(negedge clk);  // ISSUE
    checks++;
    if (bus.alu_inst !== 3'b001)
      begin errors++; $display("FAIL mid_reset_issue: inst=%h expected 1", bus.alu_inst); end
    bus.r0_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.r0_ready, bus.r1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err,
         bus.alu_inst, bus.alu_op1, bus.alu_op2} !== 32'h0)
      begin errors++; $display("FAIL mid_reset_values: rdy=%b%b vld=%b id=%b data=%h err=%b inst=%h op1=%h op2=%h expected all zero",
        bus.r0_ready, bus.r1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.alu_inst, bus.alu_op1, bus.alu_op2); end
    exp_q.delete();
    m_last = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0)
        begin errors++; $display("FAIL mid_reset_no_resp[%0d]: rsp_valid=%b expected 0", i, bus.rsp_valid); end
    end
  endtask

  task automatic test_contention();
    logic exp_order [4];
`ifdef ALU_ARBITER_RR_EN
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      txn(1'b1, 1'b1, 3'b001, 3'b010, 8'(i), 8'h10, 8'h80, 8'(i), 0, 1'b0, won, obs);
      checks++;
      if (obs[8] !== exp_order[i])
        begin errors++; $display("FAIL contention[%0d]: rsp_id=%b expected %b", i, obs[8], exp_order[i]); end
    end
  endtask

  task automatic test_random();
    logic v0, v1;
    logic [2:0] o0, o1;
    for (int i = 0; i < 25; i++) begin
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      case ($urandom_range(0, 3))
        0: o0 = 3'b001;
        1: o0 = 3'b010;
        default: o0 = 3'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: o1 = 3'b001;
        1: o1 = 3'b010;
        default: o1 = 3'($urandom);
      endcase
      txn(v0, v1, o0, o1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
          $urandom_range(0, 3), 1'($urandom), won, obs);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.r0_valid = 1'b0; bus.r0_op = 3'b000; bus.r0_a = 8'h00; bus.r0_b = 8'h00;
    bus.r1_valid = 1'b0; bus.r1_op = 3'b000; bus.r1_a = 8'h00; bus.r1_b = 8'h00;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single_add();
    test_idle();
    test_wrap();
    test_illegal_backpressure();
    test_mid_reset();
    test_contention();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have these ports, clock and reset first; clk is the single clock, rst_n is the asynchronous, active-low reset:
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous, active-low reset
  r0_valid / r1_valid  in  1  requester 0/1 has an operation pending
  r0_ready / r1_ready  out  1  requester 0/1 operation accepted this cycle
  r0_op / r1_op  in  3  operation code: 3'b001 add, 3'b010 sub, others illegal
  r0_a, r0_b / r1_a, r1_b  in  8  operands
  alu_inst  out  3  to ALU inst
  alu_op1, alu_op2  out  8  to ALU operand_1, operand_2
  alu_sol  in  8  from ALU sol (combinational)
  rsp_valid  out  1  result available
  rsp_ready  in  1  consumer accepts result
  rsp_id  out  1  requester that owns the result
  rsp_data  out  8  result
  rsp_err  out  1  illegal op code

Function
REQ-002 The block SHALL use FSM states IDLE, ISSUE and RESP.
REQ-003 In IDLE with at least one valid request, the block SHALL assert exactly one ready combinationally, latch op/a/b/id of the winner, and go to ISSUE.
REQ-004 In IDLE with no valid request, the block SHALL stay in IDLE with both ready outputs low.
REQ-005 The ready outputs SHALL be low in ISSUE and RESP; the block SHALL not accept a request while an operation is in flight.
REQ-006 In ISSUE, the block SHALL drive alu_inst/alu_op1/alu_op2 from the latched registers, register alu_sol into rsp_data at the end of the cycle, and go to RESP.
REQ-007 Outside ISSUE, the block SHALL drive alu_inst=3'b000 and alu_op1=alu_op2=8'h00.
REQ-008 In RESP, rsp_valid SHALL be 1, and rsp_data, rsp_id and rsp_err SHALL be stable until rsp_ready=1; on that cycle the block SHALL return to IDLE.
REQ-009 Latency SHALL be: grant in cycle N, rsp_valid high from cycle N+2; peak throughput one operation per 3 cycles.
REQ-010 Arithmetic SHALL be 8-bit modulo 256 with no carry/borrow output (FF+01=00, 00-01=FF).
REQ-011 An illegal op SHALL still traverse ISSUE, but with alu_inst forced to 3'b000; the block SHALL then return rsp_data=8'h00 and rsp_err=1 so that a Z/X value from the ALU is never captured.
REQ-012 For a legal op, rsp_err SHALL be 0.
REQ-013 A requester SHALL hold valid and its payload until it sees ready; the block SHALL sample the payload only on the grant cycle.
REQ-014 rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-015 On rst_n=0, the block SHALL immediately (asynchronously) enter IDLE and drive r0_ready=r1_ready=0, rsp_valid=0, rsp_id=0, rsp_data=8'h00, rsp_err=0, alu_inst=3'b000 and alu_op1=alu_op2=8'h00.
REQ-016 On reset, last_grant SHALL be set to 1 so that requester 0 wins the first contention.
REQ-017 Reset asserted during ISSUE or RESP SHALL discard the in-flight operation without producing a response.
REQ-018 After reset deassertion, the first grant SHALL be possible in the first clock edge.

Configuration
REQ-019 With macro ALU_ARBITER_RR_EN defined, arbitration SHALL be round-robin:
  - on contention, grant the requester that is not last_grant;
  - update last_grant on every grant.
REQ-020 Without ALU_ARBITER_RR_EN, arbitration SHALL be fixed priority with requester 0 always winning, and last_grant SHALL be unused.
REQ-021 The macro SHALL change no other behaviour, including ports and latency.

Verification
REQ-022 Scenario, single add: r0 op=001, a=8'h12, b=8'h34 -> r0_ready in cycle N; in cycle N+1 alu_inst=001; from N+2 rsp_valid=1, rsp_data=8'h46, rsp_id=0, rsp_err=0.
REQ-023 Scenario, wrap: r1 op=010, a=8'h00, b=8'h01 -> rsp_data=8'hFF, rsp_id=1; and op=001, a=8'hFF, b=8'h01 -> rsp_data=8'h00.
REQ-024 Scenario, contention: both valid continuously for 4 operations -> with RR_EN, grant order 0,1,0,1; without it, 0,0,0,0.
REQ-025 Scenario, illegal op and backpressure: op=3'b111 -> rsp_err=1, rsp_data=8'h00, alu_inst stays 000 in ISSUE; with rsp_ready low for 5 cycles, rsp_valid/rsp_data stay stable and both ready outputs stay 0.
REQ-026 Scenario, mid-operation reset: rst_n pulsed low during ISSUE -> all outputs return to reset values at once, no rsp_valid follows, and the next request is granted to r0.
